mmu_cp0_regfile: RTL and testbench

Responder side of the CP0↔MMU register interface. It decodes mmu_reg/readMMUReg/writeMMUReg from the CP0 register block and holds the MMU-owned CP0 registers: Index, Random, EntryLo0, EntryLo1, Context, PageMask, Wired and EntryHi. It also sequences TLBR/TLBWI/TLBWR/TLBP commands against an external TLB entry array, and loads BadVPN2/VPN2 on TLB exceptions.

---
 rtl/mmu_cp0_regfile_if.sv | 65 ++++++
 rtl/mmu_cp0_regfile.sv | 248 ++++++++++++++++++++++++
 tb/tb_mmu_cp0_regfile.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_cp0_regfile_if.sv
// ============================================================================
// Module      : mmu_cp0_regfile_if
// Description : CP0<->MMU register/TLB-sequencer bus with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MMU_REG
`define MMU_REG           [3:0]
`define MMU_REG_NONE      4'd0
`define MMU_REG_INDEX     4'd1
`define MMU_REG_RANDOM    4'd2
`define MMU_REG_ENTRYLO0  4'd3
`define MMU_REG_ENTRYLO1  4'd4
`define MMU_REG_CONTEXT   4'd5
`define MMU_REG_PAGEMASK  4'd6
`define MMU_REG_WIRED     4'd7
`define MMU_REG_ENTRYHI   4'd8
`endif

interface mmu_cp0_regfile_if #(
  parameter int IDX_W = 4
) ();
  logic `MMU_REG     mmu_reg;
  logic              readMMUReg;
  logic              writeMMUReg;
  logic [31:0]       mmu_dataIn;
  logic [31:0]       mmu_dataOut;
  logic [1:0]        tlb_cmd;
  logic              tlb_req;
  logic              tlb_busy;
  logic              tlb_done;
  logic [IDX_W-1:0]  tlb_idx;
  logic              tlb_we;
  logic [31:0]       tlb_wHi;
  logic [31:0]       tlb_wLo0;
  logic [31:0]       tlb_wLo1;
  logic [31:0]       tlb_wMask;
  logic [31:0]       tlb_rHi;
  logic [31:0]       tlb_rLo0;
  logic [31:0]       tlb_rLo1;
  logic [31:0]       tlb_rMask;
  logic              exc_we;
  logic [31:0]       exc_vaddr;

  modport master (
    output mmu_reg, readMMUReg, writeMMUReg, mmu_dataIn,
    output tlb_cmd, tlb_req,
    output tlb_rHi, tlb_rLo0, tlb_rLo1, tlb_rMask,
    output exc_we, exc_vaddr,
    input  mmu_dataOut, tlb_busy, tlb_done, tlb_idx, tlb_we,
    input  tlb_wHi, tlb_wLo0, tlb_wLo1, tlb_wMask
  );

  modport slave (
    input  mmu_reg, readMMUReg, writeMMUReg, mmu_dataIn,
    input  tlb_cmd, tlb_req,
    input  tlb_rHi, tlb_rLo0, tlb_rLo1, tlb_rMask,
    input  exc_we, exc_vaddr,
    output mmu_dataOut, tlb_busy, tlb_done, tlb_idx, tlb_we,
    output tlb_wHi, tlb_wLo0, tlb_wLo1, tlb_wMask
  );
endinterface

`default_nettype wire

// File: rtl/mmu_cp0_regfile.sv
// ============================================================================
// Module      : mmu_cp0_regfile
// Description : MMU-owned CP0 registers plus TLBR/TLBWI/TLBWR/TLBP sequencer.
//               Optional macro MMU_WIRED_EN enables the Wired register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_cp0_regfile #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              res,
  mmu_cp0_regfile_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [1:0] CMD_TLBR  = 2'd0;
  localparam logic [1:0] CMD_TLBWI = 2'd1;
  localparam logic [1:0] CMD_TLBWR = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_PROBE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q;
  logic              busy_q, done_q, we_q;
  logic [IDX_W-1:0]  tlb_idx_q;
  logic [31:0]       dout_q;

  logic              index_p_q, index_p_d;
  logic [IDX_W-1:0]  index_idx_q, index_idx_d;
  logic [IDX_W-1:0]  random_q, random_d;
  logic [29:0]       lo0_q, lo0_d, lo1_q, lo1_d;
  logic [8:0]        ptebase_q, ptebase_d;
  logic [18:0]       badvpn2_q, badvpn2_d;
  logic [15:0]       pagemask_q, pagemask_d;
  logic [18:0]       vpn2_q, vpn2_d;
  logic [7:0]        asid_q, asid_d;
`ifdef MMU_WIRED_EN
  logic [IDX_W-1:0]  wired_q, wired_d;
`endif

  logic [18:0]       w_vmask;
  logic              w_probe_hit;
  logic              w_probe_last;
  logic [31:0]       w_rdata;
  logic              w_wr_wired;

  // Page-mask bits widen the VPN2 compare; the top three VPN2 bits are always compared.
  assign w_vmask      = {3'b111, ~bus.tlb_rMask[28:13]};
  assign w_probe_hit  = (state_q == S_PROBE)
                      && ((bus.tlb_rHi[31:13] & w_vmask) == (vpn2_q & w_vmask))
                      && ((bus.tlb_rLo0[0] & bus.tlb_rLo1[0]) || (bus.tlb_rHi[7:0] == asid_q));
  assign w_probe_last = (tlb_idx_q == LAST_IDX);
  assign w_wr_wired   = bus.writeMMUReg && (bus.mmu_reg == `MMU_REG_WIRED);

  always_comb begin
    w_rdata = 32'h0;
    case (bus.mmu_reg)
      `MMU_REG_INDEX:    w_rdata = {index_p_q, {(31-IDX_W){1'b0}}, index_idx_q};
      `MMU_REG_RANDOM:   w_rdata = {{(32-IDX_W){1'b0}}, random_q};
      `MMU_REG_ENTRYLO0: w_rdata = {2'b00, lo0_q};
      `MMU_REG_ENTRYLO1: w_rdata = {2'b00, lo1_q};
      `MMU_REG_CONTEXT:  w_rdata = {ptebase_q, badvpn2_q, 4'h0};
      `MMU_REG_PAGEMASK: w_rdata = {3'b000, pagemask_q, 13'h0};
`ifdef MMU_WIRED_EN
      `MMU_REG_WIRED:    w_rdata = {{(32-IDX_W){1'b0}}, wired_q};
`endif
      `MMU_REG_ENTRYHI:  w_rdata = {vpn2_q, 5'h00, asid_q};
      default:           w_rdata = 32'h0;
    endcase
  end

  // Later assignments override earlier ones: software < exception < sequencer.
  always_comb begin
    index_p_d   = index_p_q;
    index_idx_d = index_idx_q;
    lo0_d       = lo0_q;
    lo1_d       = lo1_q;
    ptebase_d   = ptebase_q;
    badvpn2_d   = badvpn2_q;
    pagemask_d  = pagemask_q;
    vpn2_d      = vpn2_q;
    asid_d      = asid_q;
`ifdef MMU_WIRED_EN
    wired_d     = wired_q;
    if (w_wr_wired || (random_q <= wired_q)) random_d = LAST_IDX;
    else                                     random_d = random_q - 1'b1;
`else
    random_d    = random_q - 1'b1;
`endif

    if (bus.writeMMUReg) begin
      case (bus.mmu_reg)
        `MMU_REG_INDEX:    index_idx_d = bus.mmu_dataIn[IDX_W-1:0];
        `MMU_REG_ENTRYLO0: lo0_d       = bus.mmu_dataIn[29:0];
        `MMU_REG_ENTRYLO1: lo1_d       = bus.mmu_dataIn[29:0];
        `MMU_REG_CONTEXT:  ptebase_d   = bus.mmu_dataIn[31:23];
        `MMU_REG_PAGEMASK: pagemask_d  = bus.mmu_dataIn[28:13];
`ifdef MMU_WIRED_EN
        `MMU_REG_WIRED:    wired_d     = bus.mmu_dataIn[IDX_W-1:0];
`endif
        `MMU_REG_ENTRYHI: begin
          vpn2_d = bus.mmu_dataIn[31:13];
          asid_d = bus.mmu_dataIn[7:0];
        end
        default: ;
      endcase
    end

    if (bus.exc_we) begin
      vpn2_d    = bus.exc_vaddr[31:13];
      asid_d    = asid_q;
      badvpn2_d = bus.exc_vaddr[31:13];
    end

    if (state_q == S_RD) begin
      vpn2_d     = bus.tlb_rHi[31:13];
      asid_d     = bus.tlb_rHi[7:0];
      lo0_d      = bus.tlb_rLo0[29:0];
      lo1_d      = bus.tlb_rLo1[29:0];
      pagemask_d = bus.tlb_rMask[28:13];
    end else if (w_probe_hit) begin
      index_p_d   = 1'b0;
      index_idx_d = tlb_idx_q;
    end else if ((state_q == S_PROBE) && w_probe_last) begin
      index_p_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      index_p_q   <= 1'b0;
      index_idx_q <= '0;
      random_q    <= LAST_IDX;
      lo0_q       <= '0;
      lo1_q       <= '0;
      ptebase_q   <= '0;
      badvpn2_q   <= '0;
      pagemask_q  <= '0;
      vpn2_q      <= '0;
      asid_q      <= '0;
`ifdef MMU_WIRED_EN
      wired_q     <= '0;
`endif
      dout_q      <= '0;
    end else begin
      index_p_q   <= index_p_d;
      index_idx_q <= index_idx_d;
      random_q    <= random_d;
      lo0_q       <= lo0_d;
      lo1_q       <= lo1_d;
      ptebase_q   <= ptebase_d;
      badvpn2_q   <= badvpn2_d;
      pagemask_q  <= pagemask_d;
      vpn2_q      <= vpn2_d;
      asid_q      <= asid_d;
`ifdef MMU_WIRED_EN
      wired_q     <= wired_d;
`endif
      if (bus.readMMUReg) dout_q <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      tlb_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.tlb_req) begin
            busy_q <= 1'b1;
            case (bus.tlb_cmd)
              CMD_TLBR: begin
                state_q   <= S_RD;
                tlb_idx_q <= index_idx_q;
              end
              CMD_TLBWI: begin
                state_q   <= S_WR;
                tlb_idx_q <= index_idx_q;
                we_q      <= 1'b1;
              end
              CMD_TLBWR: begin
                state_q   <= S_WR;
                tlb_idx_q <= random_q;
                we_q      <= 1'b1;
              end
              default: begin
                state_q   <= S_PROBE;
                tlb_idx_q <= '0;
              end
            endcase
          end
        end
        S_RD, S_WR: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_PROBE: begin
          if (w_probe_hit || w_probe_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            tlb_idx_q <= tlb_idx_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mmu_dataOut = dout_q;
  assign bus.tlb_busy    = busy_q;
  assign bus.tlb_done    = done_q;
  assign bus.tlb_we      = we_q;
  assign bus.tlb_idx     = tlb_idx_q;
  assign bus.tlb_wHi     = {vpn2_q, 5'h00, asid_q};
  assign bus.tlb_wLo0    = {2'b00, lo0_q};
  assign bus.tlb_wLo1    = {2'b00, lo1_q};
  assign bus.tlb_wMask   = {3'b000, pagemask_q, 13'h0};

  logic w_unused;
  assign w_unused = ^{bus.tlb_rHi[12:8], bus.tlb_rLo0[31:30], bus.tlb_rLo1[31:30],
                      bus.tlb_rMask[31:29], bus.tlb_rMask[12:0], bus.exc_vaddr[12:0],
                      w_wr_wired};

endmodule

`default_nettype wire

// File: tb/tb_mmu_cp0_regfile.sv
// ============================================================================
// Module      : tb_mmu_cp0_regfile
// Description : Directed self-checking bench for mmu_cp0_regfile with a TLB array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MMU_REG
`define MMU_REG           [3:0]
`define MMU_REG_NONE      4'd0
`define MMU_REG_INDEX     4'd1
`define MMU_REG_RANDOM    4'd2
`define MMU_REG_ENTRYLO0  4'd3
`define MMU_REG_ENTRYLO1  4'd4
`define MMU_REG_CONTEXT   4'd5
`define MMU_REG_PAGEMASK  4'd6
`define MMU_REG_WIRED     4'd7
`define MMU_REG_ENTRYHI   4'd8
`endif

module tb_mmu_cp0_regfile;

  logic clk;
  logic res;
  int   n_tests;
  int   n_fail;

  mmu_cp0_regfile_if #(.IDX_W(4)) bus ();

  mmu_cp0_regfile #(.NUM_ENTRIES(16), .IDX_W(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TLB entry array model: combinational read, write on DUT strobe or bench preset
  logic [31:0] t_hi [16];
  logic [31:0] t_lo0 [16];
  logic [31:0] t_lo1 [16];
  logic [31:0] t_mask [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_hi, pre_lo0, pre_lo1, pre_mask;

  always @(posedge clk) begin
    if (bus.tlb_we) begin
      t_hi[bus.tlb_idx]   <= bus.tlb_wHi;
      t_lo0[bus.tlb_idx]  <= bus.tlb_wLo0;
      t_lo1[bus.tlb_idx]  <= bus.tlb_wLo1;
      t_mask[bus.tlb_idx] <= bus.tlb_wMask;
    end else if (pre_we) begin
      t_hi[pre_idx]   <= pre_hi;
      t_lo0[pre_idx]  <= pre_lo0;
      t_lo1[pre_idx]  <= pre_lo1;
      t_mask[pre_idx] <= pre_mask;
    end
  end

  assign bus.tlb_rHi   = t_hi[bus.tlb_idx];
  assign bus.tlb_rLo0  = t_lo0[bus.tlb_idx];
  assign bus.tlb_rLo1  = t_lo1[bus.tlb_idx];
  assign bus.tlb_rMask = t_mask[bus.tlb_idx];

  task automatic preset(input logic [3:0] i, input logic [31:0] hi, input logic [31:0] l0,
                        input logic [31:0] l1, input logic [31:0] m);
    pre_idx = i; pre_hi = hi; pre_lo0 = l0; pre_lo1 = l1; pre_mask = m; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d);
    bus.mmu_reg = r; bus.mmu_dataIn = d; bus.writeMMUReg = 1'b1;
    @(negedge clk);
    bus.writeMMUReg = 1'b0; bus.mmu_reg = `MMU_REG_NONE;
  endtask

  task automatic rd(input logic [3:0] r, output logic [31:0] d);
    bus.mmu_reg = r; bus.readMMUReg = 1'b1;
    @(negedge clk);
    bus.readMMUReg = 1'b0; bus.mmu_reg = `MMU_REG_NONE;
    d = bus.mmu_dataOut;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    res = 1'b0;
    for (int i = 0; i < 16; i++)
      preset(i[3:0], 32'h8000_0000 | (i << 13), 32'h0, 32'h0, 32'h0);
    preset(4'd7, 32'h0040_2011, 32'h0, 32'h0, 32'h0);
    n_tests++;
    if ({bus.mmu_dataOut, bus.tlb_busy, bus.tlb_done, bus.tlb_we, bus.tlb_idx} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got dout=%h busy=%b done=%b we=%b idx=%h, expected all zero",
               bus.mmu_dataOut, bus.tlb_busy, bus.tlb_done, bus.tlb_we, bus.tlb_idx);
    end
    res = 1'b1;
    repeat (3) @(negedge clk);
    rd(`MMU_REG_RANDOM, v);
    n_tests++;
    if (v !== 32'd12) begin n_fail++; $display("FAIL reset_random: got %h expected %h", v, 32'd12); end
    rd(`MMU_REG_ENTRYHI, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_entryhi: got %h expected 0", v); end
    rd(`MMU_REG_INDEX, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_index: got %h expected 0", v); end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wr(`MMU_REG_ENTRYHI, 32'hFFFF_FFFF);
    rd(`MMU_REG_ENTRYHI, v);
    n_tests++;
    if (v !== 32'hFFFF_E0FF) begin n_fail++; $display("FAIL entryhi_mask: got %h expected FFFFE0FF", v); end
    wr(`MMU_REG_ENTRYLO0, 32'hFFFF_FFFF);
    rd(`MMU_REG_ENTRYLO0, v);
    n_tests++;
    if (v !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL entrylo0_mask: got %h expected 3FFFFFFF", v); end
    wr(`MMU_REG_PAGEMASK, 32'hFFFF_FFFF);
    rd(`MMU_REG_PAGEMASK, v);
    n_tests++;
    if (v !== 32'h1FFF_E000) begin n_fail++; $display("FAIL pagemask_mask: got %h expected 1FFFE000", v); end
    wr(`MMU_REG_CONTEXT, 32'hFFFF_FFFF);
    rd(`MMU_REG_CONTEXT, v);
    n_tests++;
    if (v !== 32'hFF80_0000) begin n_fail++; $display("FAIL context_mask: got %h expected FF800000", v); end
    wr(`MMU_REG_INDEX, 32'hFFFF_FFFF);
    rd(`MMU_REG_INDEX, v);
    n_tests++;
    if (v !== 32'h0000_000F) begin n_fail++; $display("FAIL index_mask: got %h expected 0000000F", v); end
    wr(`MMU_REG_NONE, 32'hFFFF_FFFF);
    rd(`MMU_REG_NONE, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL none_read: got %h expected 0", v); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [3:0]  model;
    wr(`MMU_REG_WIRED, 32'd5);
    rd(`MMU_REG_WIRED, v);
`ifdef MMU_WIRED_EN
    n_tests++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL wired_read: got %h expected 5", v); end
    model = 4'd14;
    wr(`MMU_REG_WIRED, 32'd5);
`else
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL wired_read: got %h expected 0", v); end
    model = 4'd0;
`endif
    bus.mmu_reg = `MMU_REG_RANDOM; bus.readMMUReg = 1'b1;
`ifdef MMU_WIRED_EN
    model = 4'd15;
`else
    @(negedge clk);
    model = bus.mmu_dataOut[3:0] - 4'd1;
`endif
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.mmu_dataOut !== {28'h0, model}) begin
        n_fail++;
        $display("FAIL random_seq[%0d]: got %h expected %h", k, bus.mmu_dataOut, model);
      end
`ifdef MMU_WIRED_EN
      model = (model <= 4'd5) ? 4'd15 : model - 4'd1;
`else
      model = model - 4'd1;
`endif
    end
    bus.readMMUReg = 1'b0; bus.mmu_reg = `MMU_REG_NONE;
  endtask

  task automatic test_tlbwi();
    wr(`MMU_REG_INDEX, 32'd3);
    wr(`MMU_REG_ENTRYLO0, 32'h3FFF_FFFF);
    bus.tlb_cmd = 2'd1; bus.tlb_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.tlb_req = 1'b0;
      n_tests++;
      if (bus.tlb_we !== (k == 1) || bus.tlb_done !== (k == 2)) begin
        n_fail++;
        $display("FAIL tlbwi_cycle%0d: got we=%b done=%b expected we=%b done=%b",
                 k, bus.tlb_we, bus.tlb_done, (k == 1), (k == 2));
      end
      if (k == 1) begin
        n_tests++;
        if (bus.tlb_idx !== 4'd3 || bus.tlb_wLo0 !== 32'h3FFF_FFFF || bus.tlb_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL tlbwi_write: got idx=%h wLo0=%h busy=%b expected 3 3FFFFFFF 1",
                   bus.tlb_idx, bus.tlb_wLo0, bus.tlb_busy);
        end
      end
    end
    n_tests++;
    if (t_lo0[3] !== 32'h3FFF_FFFF || t_hi[3] !== 32'hFFFF_E0FF) begin
      n_fail++;
      $display("FAIL tlbwi_array: got hi=%h lo0=%h expected FFFFE0FF 3FFFFFFF", t_hi[3], t_lo0[3]);
    end
  endtask

  task automatic run_probe(input logic inject, output int done_at, output int n_done, output int n_we);
    done_at = 0; n_done = 0; n_we = 0;
    bus.tlb_cmd = 2'd3; bus.tlb_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.tlb_req = 1'b0;
      if (inject && k == 3) begin bus.tlb_cmd = 2'd1; bus.tlb_req = 1'b1; end
      if (bus.tlb_done) begin n_done++; if (done_at == 0) done_at = k; end
      if (bus.tlb_we) n_we++;
    end
  endtask

  task automatic test_probe();
    logic [31:0] v;
    int done_at, n_done, n_we;
    wr(`MMU_REG_ENTRYHI, 32'h0040_2011);
    run_probe(1'b0, done_at, n_done, n_we);
    n_tests++;
    if (done_at !== 9 || n_done !== 1) begin
      n_fail++; $display("FAIL probe_hit_timing: got done_at=%0d pulses=%0d expected 9 1", done_at, n_done);
    end
    rd(`MMU_REG_INDEX, v);
    n_tests++;
    if (v !== 32'h0000_0007) begin n_fail++; $display("FAIL probe_hit_index: got %h expected 00000007", v); end
    // Miss case, with a second request injected while the scan is busy
    wr(`MMU_REG_ENTRYHI, 32'h1234_6000);
    run_probe(1'b1, done_at, n_done, n_we);
    n_tests++;
    if (done_at !== 17 || n_done !== 1 || n_we !== 0) begin
      n_fail++;
      $display("FAIL probe_miss_timing: got done_at=%0d pulses=%0d we=%0d expected 17 1 0", done_at, n_done, n_we);
    end
    rd(`MMU_REG_INDEX, v);
    n_tests++;
    if (v !== 32'h8000_0007) begin n_fail++; $display("FAIL probe_miss_index: got %h expected 80000007", v); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    wr(`MMU_REG_ENTRYHI, 32'h0000_00AB);
    bus.exc_vaddr = 32'h1234_5678; bus.exc_we = 1'b1;
    @(negedge clk);
    bus.exc_we = 1'b0;
    rd(`MMU_REG_ENTRYHI, v);
    n_tests++;
    if (v !== 32'h1234_40AB) begin n_fail++; $display("FAIL exc_entryhi: got %h expected 123440AB", v); end
    rd(`MMU_REG_CONTEXT, v);
    n_tests++;
    if (v !== 32'hFF89_1A20) begin n_fail++; $display("FAIL exc_context: got %h expected FF891A20", v); end
    bus.mmu_reg = `MMU_REG_ENTRYHI; bus.mmu_dataIn = 32'hFFFF_FFFF; bus.writeMMUReg = 1'b1;
    bus.exc_vaddr = 32'h0000_6000; bus.exc_we = 1'b1;
    @(negedge clk);
    bus.writeMMUReg = 1'b0; bus.exc_we = 1'b0; bus.mmu_reg = `MMU_REG_NONE;
    rd(`MMU_REG_ENTRYHI, v);
    n_tests++;
    if (v !== 32'h0000_60AB) begin n_fail++; $display("FAIL exc_priority: got %h expected 000060AB", v); end
    rd(`MMU_REG_CONTEXT, v);
    n_tests++;
    if (v !== 32'hFF80_0030) begin n_fail++; $display("FAIL exc_priority_ctx: got %h expected FF800030", v); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] v;
    int done_at, n_done;
    wr(`MMU_REG_ENTRYHI, 32'h1234_6000);
    bus.tlb_cmd = 2'd3; bus.tlb_req = 1'b1;
    @(negedge clk);
    bus.tlb_req = 1'b0;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.tlb_busy !== 1'b0 || bus.tlb_done !== 1'b0 || bus.tlb_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b idx=%h expected 0 0 0",
               bus.tlb_busy, bus.tlb_done, bus.tlb_idx);
    end
    res = 1'b1;
    n_done = 0;
    repeat (20) begin @(negedge clk); if (bus.tlb_done) n_done++; end
    n_tests++;
    if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done); end
    rd(`MMU_REG_INDEX, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL abort_index: got %h expected 0", v); end
    preset(4'd7, 32'h0040_2011, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF);
    wr(`MMU_REG_INDEX, 32'd7);
    bus.tlb_cmd = 2'd0; bus.tlb_req = 1'b1;
    done_at = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.tlb_req = 1'b0;
      if (bus.tlb_done && done_at == 0) done_at = k;
    end
    n_tests++;
    if (done_at !== 2) begin n_fail++; $display("FAIL tlbr_timing: got done_at=%0d expected 2", done_at); end
    rd(`MMU_REG_ENTRYHI, v);
    n_tests++;
    if (v !== 32'h0040_2011) begin n_fail++; $display("FAIL tlbr_entryhi: got %h expected 00402011", v); end
    rd(`MMU_REG_ENTRYLO0, v);
    n_tests++;
    if (v !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL tlbr_lo0: got %h expected 3FFFFFFF", v); end
    rd(`MMU_REG_ENTRYLO1, v);
    n_tests++;
    if (v !== 32'h1234_5678) begin n_fail++; $display("FAIL tlbr_lo1: got %h expected 12345678", v); end
    rd(`MMU_REG_PAGEMASK, v);
    n_tests++;
    if (v !== 32'h1FFF_E000) begin n_fail++; $display("FAIL tlbr_mask: got %h expected 1FFFE000", v); end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    res = 1'b0;
    pre_we = 1'b0; pre_idx = 4'd0;
    pre_hi = 32'h0; pre_lo0 = 32'h0; pre_lo1 = 32'h0; pre_mask = 32'h0;
    bus.mmu_reg = `MMU_REG_NONE; bus.readMMUReg = 1'b0; bus.writeMMUReg = 1'b0;
    bus.mmu_dataIn = 32'h0; bus.tlb_cmd = 2'd0; bus.tlb_req = 1'b0;
    bus.exc_we = 1'b0; bus.exc_vaddr = 32'h0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_random();
    test_tlbwi();
    test_probe();
    test_exception();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
